// File: rtl/scan_chain_host_ctrl.sv
// Byte-oriented host controller for the accumulator core's scan chain:
// serialises host bytes into the chain, returns displaced bits, and runs the core.
module scan_chain_host_ctrl #(
  parameter int CHAIN_LEN = 152
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_arg,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       scan_enable,
  output logic       scan_in,
  output logic       proc_en,
  input  logic       scan_out,
  input  logic       halt,
  output logic       busy,
  output logic       done,
  output logic       halted
);

  localparam int NBYTES = CHAIN_LEN / 8;
  localparam int CW     = $clog2(NBYTES + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_OUT, S_RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    cap_q, cap_d;
  logic [7:0]    run_q, run_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          in_ready_q, in_ready_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          scan_enable_q, scan_enable_d;
  logic          scan_in_q, scan_in_d;
  logic          proc_en_q, proc_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          halted_q, halted_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      byte_cnt_q    <= '0;
      bit_q         <= '0;
      sh_q          <= '0;
      cap_q         <= '0;
      run_q         <= '0;
      cmd_ready_q   <= 1'b1;
      in_ready_q    <= 1'b0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      scan_enable_q <= 1'b0;
      scan_in_q     <= 1'b0;
      proc_en_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      bit_q         <= bit_d;
      sh_q          <= sh_d;
      cap_q         <= cap_d;
      run_q         <= run_d;
      cmd_ready_q   <= cmd_ready_d;
      in_ready_q    <= in_ready_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      scan_enable_q <= scan_enable_d;
      scan_in_q     <= scan_in_d;
      proc_en_q     <= proc_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      halted_q      <= halted_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    bit_d         = bit_q;
    sh_d          = sh_q;
    cap_d         = cap_q;
    run_d         = run_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    scan_enable_d = scan_enable_q;
    scan_in_d     = scan_in_q;
    proc_en_d     = proc_en_q;
    halted_d      = halted_q;
    done_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          halted_d = 1'b0;
          case (cmd_op)
            2'b00: begin
              state_d    = S_LOAD;
              byte_cnt_d = '0;
            end
            2'b01: begin
              state_d   = S_RUN;
              run_d     = cmd_arg;
              proc_en_d = 1'b1;
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          sh_d          = in_data;
          scan_in_d     = in_data[7];
          scan_enable_d = 1'b1;
          bit_d         = '0;
          state_d       = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // scan_out is sampled before the core shifts on this same edge
        cap_d     = {cap_q[6:0], scan_out};
        scan_in_d = sh_q[6];
        sh_d      = {sh_q[6:0], 1'b0};
        bit_d     = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          scan_enable_d = 1'b0;
          scan_in_d     = 1'b0;
          out_data_d    = {cap_q[6:0], scan_out};
          out_valid_d   = 1'b1;
          state_d       = S_OUT;
        end
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          byte_cnt_d  = byte_cnt_q + CW'(1);
          if (byte_cnt_q == CW'(NBYTES - 1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_RUN: begin
        // run_q == 0 means run until halt; a bounded run stops after its last cycle
        if (proc_en_q) begin
          if (halt) begin
            proc_en_d = 1'b0;
            halted_d  = 1'b1;
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end else if (run_q == 8'd1) begin
            proc_en_d = 1'b0;
          end else if (run_q != 8'd0) begin
            run_d = run_q - 8'd1;
          end
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    in_ready_d  = (state_d == S_LOAD);
    busy_d      = (state_d != S_IDLE);
  end

  assign cmd_ready   = cmd_ready_q;
  assign in_ready    = in_ready_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign scan_enable = scan_enable_q;
  assign scan_in     = scan_in_q;
  assign proc_en     = proc_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_scan_chain_host_ctrl.sv
// Bench for scan_chain_host_ctrl: a shift-register stand-in for the core chain,
// a table of RUN/NOP vectors, directed SCAN sequences and randomized stalled scans.
module tb_scan_chain_host_ctrl;
  localparam int CHAIN_LEN = 152;
  localparam int NB        = CHAIN_LEN / 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b10;
  logic [7:0] cmd_arg = 8'h00;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       scan_enable, scan_in, proc_en;
  logic       scan_out;
  logic       halt = 1'b0;
  logic       busy, done, halted;

  always #5 clk = ~clk;

  scan_chain_host_ctrl #(.CHAIN_LEN(CHAIN_LEN)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .scan_enable(scan_enable), .scan_in(scan_in), .proc_en(proc_en),
    .scan_out(scan_out), .halt(halt),
    .busy(busy), .done(done), .halted(halted)
  );

  // Core stand-in: chain shifts toward the MSB, scan_out is the MSB
  logic [CHAIN_LEN-1:0] chain = '0;
  logic [CHAIN_LEN-1:0] core_val = '0;
  logic                 core_set = 1'b0;
  always @(posedge clk) begin
    if (core_set)         chain <= core_val;
    else if (scan_enable) chain <= {chain[CHAIN_LEN-2:0], scan_in};
  end
  assign scan_out = chain[CHAIN_LEN-1];

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [CHAIN_LEN-1:0] got,
                       input logic [CHAIN_LEN-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // Protocol invariants observed every cycle out of reset
  int  se_cnt = 0, v_overlap = 0, v_stall = 0, v_inready = 0, v_done2 = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (scan_enable) se_cnt <= se_cnt + 1;
      if (scan_enable && proc_en) v_overlap <= v_overlap + 1;
      if (scan_enable && (in_ready || out_valid)) v_stall <= v_stall + 1;
      if (in_ready && proc_en) v_inready <= v_inready + 1;
      if (done && done_prev) v_done2 <= v_done2 + 1;
      done_prev <= done;
    end else begin
      done_prev <= 1'b0;
    end
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] arg;
    int         halt_at;   // halt rises during this proc_en cycle (1-based), 0 = never
    bit         halt_pre;  // halt already high at acceptance
    bit         busy_cmd;  // keep offering a NOP while busy
    int         exp_pe;    // proc_en high cycles
    int         exp_didx;  // cycle (0 = first after acceptance) in which done is high
    bit         exp_halted;
  } vec_t;

  vec_t tbl[10];

  task automatic wait_ready();
    for (int i = 0; i < 400 && !cmd_ready; i++) @(negedge clk);
    check("cmd_ready_wait", cmd_ready, 1);
  endtask

  task automatic preset(input logic [CHAIN_LEN-1:0] v);
    core_val = v;
    core_set = 1'b1;
    @(negedge clk);
    core_set = 1'b0;
  endtask

  function automatic logic [CHAIN_LEN-1:0] rand_chain();
    logic [CHAIN_LEN-1:0] r = '0;
    for (int i = 0; i < 5; i++) r = {r[CHAIN_LEN-33:0], 32'($urandom())};
    return r;
  endfunction

  task automatic run_vec(input string nm, input vec_t v);
    int pe = 0;
    int didx = -1;
    int rdy_bad = 0;
    logic hv = 1'b0;
    wait_ready();
    halt = v.halt_pre;
    in_valid = 1'b1;
    in_data = 8'hA5;
    cmd_op = v.op;
    cmd_arg = v.arg;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_op = 2'b10;
    cmd_valid = v.busy_cmd;
    for (int k = 0; k < 600; k++) begin
      if (proc_en) begin
        pe++;
        if (v.halt_at != 0 && pe == v.halt_at) halt = 1'b1;
      end
      if (done) begin
        didx = k;
        hv = halted;
        break;
      end
      if (cmd_ready && v.op == 2'b01) rdy_bad++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    halt = 1'b0;
    in_valid = 1'b0;
    check({nm, "_pe_cycles"}, pe, v.exp_pe);
    check({nm, "_done_cycle"}, didx, v.exp_didx);
    check({nm, "_halted"}, hv, v.exp_halted);
    check({nm, "_ready_while_busy"}, rdy_bad, 0);
    @(negedge clk);
  endtask

  // mode 0: no stalls, 1: random stalls, 2: fixed 5-cycle out stall and 4-cycle in gap
  task automatic do_scan(input string nm, input logic [CHAIN_LEN-1:0] data, input int mode,
                         output logic [CHAIN_LEN-1:0] outv, output int lat);
    int idx = 0, got = 0, t0 = -1, td = -1, wait_o = 0, wait_i = 0, se0;
    wait_ready();
    se0 = se_cnt;
    outv = '0;
    cmd_op = 2'b00;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'b10;
    for (int t = 0; t < 3000; t++) begin
      if (done) begin
        td = t;
        break;
      end
      in_valid = (idx < NB);
      if (mode == 1 && $urandom_range(0, 2) == 0) in_valid = 1'b0;
      if (mode == 2 && idx == 5 && in_ready && wait_i < 4) begin
        in_valid = 1'b0;
        wait_i++;
      end
      in_data = (idx < NB) ? data[CHAIN_LEN-1-8*idx -: 8] : 8'h00;
      out_ready = 1'b1;
      if (mode == 1 && $urandom_range(0, 2) == 0) out_ready = 1'b0;
      if (mode == 2 && got == 3 && out_valid && wait_o < 5) begin
        out_ready = 1'b0;
        wait_o++;
      end
      if (in_valid && in_ready) begin
        if (t0 < 0) t0 = t;
        idx++;
      end
      if (out_valid && out_ready) begin
        if (got < NB) outv[CHAIN_LEN-1-8*got -: 8] = out_data;
        got++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    lat = td - t0;
    check({nm, "_done_seen"}, (td >= 0), 1);
    check({nm, "_bytes_in"}, idx, NB);
    check({nm, "_bytes_out"}, got, NB);
    check({nm, "_chain"}, chain, data);
    check({nm, "_se_cycles"}, se_cnt - se0, CHAIN_LEN);
    @(negedge clk);
  endtask

  task automatic reset_mid(input string nm, input logic [1:0] op);
    int k;
    wait_ready();
    cmd_op = op;
    cmd_arg = 8'd0;
    cmd_valid = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h5A;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (k = 0; k < 20 && !(scan_enable || proc_en); k++) @(negedge clk);
    check({nm, "_started"}, scan_enable | proc_en, 1);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check({nm, "_async_outputs"},
          {cmd_ready, in_ready, out_valid, scan_enable, scan_in, proc_en, busy, done, halted, out_data},
          {1'b1, 8'b0, 8'h00});
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check({nm, "_idle_after"}, {cmd_ready, busy, done}, 3'b100);
  endtask

  localparam logic [CHAIN_LEN-1:0] LOADV   = {88'h0, 64'hE4E3E2E1E0_01E009};
  localparam logic [CHAIN_LEN-1:0] UNLOADV = {88'h0, 64'hE4E3E2E1E0_0BE429};

  initial begin
    logic [CHAIN_LEN-1:0] p, b, o1, o2;
    int lat;
    vec_t v;

    tbl[0] = '{2'b01, 8'd0,   3, 1'b0, 1'b1, 3,   3,   1'b1};
    tbl[1] = '{2'b10, 8'd0,   0, 1'b0, 1'b0, 0,   0,   1'b0};
    tbl[2] = '{2'b01, 8'd1,   0, 1'b0, 1'b0, 1,   2,   1'b0};
    tbl[3] = '{2'b01, 8'd4,   4, 1'b0, 1'b1, 4,   4,   1'b1};
    tbl[4] = '{2'b01, 8'd4,   5, 1'b0, 1'b0, 4,   5,   1'b0};
    tbl[5] = '{2'b01, 8'd0,   0, 1'b1, 1'b0, 1,   1,   1'b1};
    tbl[6] = '{2'b01, 8'd255, 0, 1'b0, 1'b1, 255, 256, 1'b0};
    tbl[7] = '{2'b01, 8'd5,   0, 1'b1, 1'b1, 1,   1,   1'b1};
    tbl[8] = '{2'b11, 8'd7,   0, 1'b0, 1'b0, 0,   0,   1'b0};
    tbl[9] = '{2'b01, 8'd9,   2, 1'b0, 1'b0, 2,   2,   1'b1};

    // Power-on reset
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {cmd_ready, in_ready, out_valid, scan_enable, scan_in, proc_en, busy, done, halted, out_data},
          {1'b1, 8'b0, 8'h00});
    rst = 1'b1;
    @(negedge clk);
    check("reset_release_ready", {cmd_ready, busy}, 2'b10);

    preset(rand_chain());
    reset_mid("rst_mid_shift", 2'b00);
    reset_mid("rst_mid_run", 2'b01);

    // Program load, unstalled
    p = rand_chain();
    preset(p);
    do_scan("scan_load", LOADV, 0, o1, lat);
    check("scan_load_out", o1, p);
    check("scan_load_latency", lat, 190);
    check("core_state", chain[2:0], 3'b001);
    check("core_pc", chain[7:3], 5'd1);
    check("core_ir", chain[15:8], 8'hE0);
    check("core_acc", chain[23:16], 8'h01);
    check("core_mem0_4", chain[63:24], 40'hE4E3E2E1E0);

    v = '{2'b01, 8'd8, 0, 1'b0, 1'b1, 8, 9, 1'b0};
    run_vec("run8", v);

    // The core's program leaves ACC=0B, IR=E4, PC=5 after those eight cycles
    preset({LOADV[CHAIN_LEN-1:24], 8'h0B, 8'hE4, 8'h29});
    do_scan("scan_unload", '0, 0, o1, lat);
    check("scan_unload_out", o1, UNLOADV);

    foreach (tbl[i]) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Backpressure must not change the data
    p = rand_chain();
    b = rand_chain();
    preset(p);
    do_scan("bp_ref", b, 0, o1, lat);
    preset(p);
    do_scan("bp_stall", b, 2, o2, lat);
    check("bp_same_out", o2, o1);
    check("bp_out_model", o2, p);

    for (int r = 0; r < 4; r++) begin
      p = rand_chain();
      b = rand_chain();
      preset(p);
      do_scan($sformatf("rand%0d", r), b, 1, o1, lat);
      check($sformatf("rand%0d_out", r), o1, p);
    end

    check("inv_se_proc_overlap", v_overlap, 0);
    check("inv_se_during_stall", v_stall, 0);
    check("inv_in_ready_in_run", v_inready, 0);
    check("inv_done_one_cycle", v_done2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/scan_chain_host_ctrl.md
# scan_chain_host_ctrl

Byte-oriented host controller sitting directly upstream of `accumulator_microcontroller`. It drives the core's `scan_enable`/`scan_in`/`proc_en` and samples `scan_out`/`halt`. Host bytes are serialised into the scan chain while the displaced chain contents are returned as bytes. The processor can then be run for a bounded cycle count or until halt. It shares the core's clock, and replaces bench-level bit-banging in the integrated design.

## Interface
- `CHAIN_LEN`, 152, scan chain length in bits; must be a multiple of 8 (152 → 19 bytes).
- `clk` in 1: single clock, shared with the core.
- `rst` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1, `cmd_ready` out 1, `cmd_op` in 2, `cmd_arg` in 8: command port.
  - `cmd_op`: 00 = SCAN, 01 = RUN, 1x = NOP.
  - `cmd_arg`: RUN cycle count; 0 = run until halt.
- `in_data` in 8, `in_valid` in 1, `in_ready` out 1: bytes to shift into the chain.
- `out_data` out 8, `out_valid` out 1, `out_ready` in 1: bytes shifted out of the chain.
- `scan_enable` out 1, `scan_in` out 1, `proc_en` out 1: to core.
- `scan_out` in 1, `halt` in 1: from core.
- `busy` out 1: high when not IDLE.
- `done` out 1: one-cycle pulse on command completion.
- `halted` out 1: sticky; the last RUN ended on halt.

## Operation
- States: IDLE, LOAD, SHIFT, OUT, RUN. All outputs are registered.
- **IDLE:** `cmd_ready`=1. Handshake is `cmd_valid&&cmd_ready` at a rising edge. Accepting any command clears `halted`.
  - SCAN → LOAD, with byte counter = 0.
  - RUN → RUN, with count = `cmd_arg`.
  - NOP → `done` pulses next cycle; stay in IDLE.
- **LOAD:** `in_ready`=1 and `scan_enable`=0.
  - On the `in` handshake, latch the byte, drive `scan_in`=`in_data[7]` and `scan_enable`=1, then → SHIFT.
  - While `in_valid`=0, stall with the chain frozen.
- **SHIFT:** exactly 8 rising edges with `scan_enable`=1.
  - On each edge, the core shifts in `scan_in`.
  - On each edge, the controller captures `cap <= {cap[6:0], scan_out}`, sampling the pre-edge value.
  - On each edge, the controller advances `scan_in` to the next lower byte bit, MSB first.
  - On the 8th edge: `scan_enable`→0, `out_data`←captured byte, `out_valid`→1, → OUT.
- **OUT:** hold `out_data`/`out_valid` until `out_ready`.
  - On the handshake, increment the byte counter.
  - If the counter reaches `CHAIN_LEN/8`: `done` pulses, → IDLE. Otherwise → LOAD.
- Byte ordering:
  - The first host byte lands in chain bits [CHAIN_LEN-1:CHAIN_LEN-8]; the last host byte lands in [7:0].
  - `out` bytes use the same ordering and carry the previous chain contents.
  - Bit layout (LSB end): [2:0] state, [7:3] PC, [15:8] IR, [23:16] ACC, then MEM[0], MEM[1], … upward.
- **RUN:** `proc_en`=1 from the cycle after acceptance.
  - N>0: `proc_en` stays high for exactly N cycles, then falls; `done` pulses in the cycle after the fall.
  - N=0: `proc_en` stays high until halt.
  - `halt` sampled high while `proc_en`=1 (either mode): `proc_en`→0 at the next edge, `done` pulses, `halted`→1, → IDLE.
- `scan_enable` and `proc_en` are never high simultaneously.

## Timing
- Reset values:
  - state IDLE; `cmd_ready`=1.
  - `in_ready`=`out_valid`=`scan_enable`=`scan_in`=`proc_en`=`busy`=`done`=`halted`=0.
  - `out_data`=0.
- SCAN throughput with no stalls: 10 cycles/byte (1 LOAD + 8 SHIFT + 1 OUT); 190 cycles for 152 bits.
- Stall in LOAD or OUT: `scan_enable` stays 0 and the core chain is untouched.
- `in_valid` asserted outside LOAD: ignored (`in_ready`=0), data not consumed.
- `cmd_valid` while busy: not accepted.
- `halt` already high at RUN acceptance: `proc_en` is high for exactly 1 cycle, then the halt path applies.
- Reset mid-SHIFT or mid-RUN: the controller returns to IDLE immediately. The chain is left partially shifted; no `done` is issued.

## Test plan
- **Reset:** assert `rst`=0 mid-cycle → all outputs at reset values asynchronously; `cmd_ready`=1 after release.
- **SCAN load:** send 19 bytes: 11×0x00, E4, E3, E2, E1, E0, 01, E0, 09.
  - Core regs must read: state=001, PC=1, IR=E0, ACC=01, MEM[0..4]=E0..E4.
  - `done` pulses once, 190 cycles after the first byte with no stalls.
- **RUN 8:** core ACC=0x0B; `proc_en` high for exactly 8 cycles; `halted`=0.
- **SCAN unload:** send 19×0x00 → `out` bytes are 11×0x00, E4, E3, E2, E1, E0, 0B, E4, 29 (PC=5, state=001).
- **Halt:** RUN with `cmd_arg`=0 and core `halt` forced high on cycle 3 → `proc_en` falls the next edge, `done` pulses, `halted`=1.
- **Backpressure:** `out_ready` low for 5 cycles and `in_valid` gaps during a SCAN → `scan_enable` is 0 throughout the stalls, data is identical to the unstalled run, and `scan_enable` shows exactly 152 high cycles in total.
